// File: rtl/mod_toggle_counter.sv
// Programmable modulo-M up/down counter; each wrap pulses tc for one cycle and
// flips q, acting as the T-input source for the downstream divider stage.
module mod_toggle_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             q,
  output logic             qbar
);

  logic [WIDTH-1:0] mod_r, mod_nxt;
  logic [WIDTH-1:0] cnt_r, cnt_nxt;
  logic             tc_r, tc_nxt;
  logic             q_r, q_nxt;
  logic [WIDTH-1:0] last_cnt;
  logic             wrap;

  // M-1 taken modulo 2**WIDTH: mod==0 (M = 2**WIDTH) lands on all-ones,
  // so the WIDTH+1-bit effective modulus never has to be materialised.
  assign last_cnt = mod_r - WIDTH'(1);

  assign wrap = en && !load && (up ? (cnt_r == last_cnt) : (cnt_r == '0));

  always_comb begin
    mod_nxt = mod_r;
    cnt_nxt = cnt_r;
    tc_nxt  = 1'b0;
    q_nxt   = q_r;
    if (load) begin
      mod_nxt = mod_in;
      cnt_nxt = '0;
    end else if (en) begin
      if (up) cnt_nxt = wrap ? '0       : cnt_r + WIDTH'(1);
      else    cnt_nxt = wrap ? last_cnt : cnt_r - WIDTH'(1);
      tc_nxt = wrap;
      q_nxt  = q_r ^ wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mod_r <= WIDTH'(DEFAULT_MOD);
      cnt_r <= '0;
      tc_r  <= 1'b0;
      q_r   <= 1'b0;
    end else begin
      mod_r <= mod_nxt;
      cnt_r <= cnt_nxt;
      tc_r  <= tc_nxt;
      q_r   <= q_nxt;
    end
  end

  assign count = cnt_r;
  assign tc    = tc_r;
  assign q     = q_r;
  assign qbar  = ~q_r;

endmodule

// File: tb/tb_mod_toggle_counter.sv
// Directed bench: stimulus pushes hand-computed expected outputs into a queue,
// a monitor pops and compares one entry per clock after the edge.
module tb_mod_toggle_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] mod_in;
  logic [W-1:0] count;
  logic         tc, q, qbar;

  typedef struct {
    int           id;
    logic [W-1:0] cnt;
    logic         tc;
    logic         q;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  mod_toggle_counter #(.WIDTH(W), .DEFAULT_MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .mod_in(mod_in),
    .count(count), .tc(tc), .q(q), .qbar(qbar)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [W-1:0] m, input int ec, input logic etc, input logic eq);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; mod_in = m;
    step_id++;
    x.id = step_id; x.cnt = W'(ec); x.tc = etc; x.q = eq;
    exp_q.push_back(x);
  endtask

  task automatic run_up(input int n, input int start, input int modm, input logic q0);
    int c = start;
    logic qq = q0;
    for (int i = 0; i < n; i++) begin
      logic w = (c == modm - 1);
      c = w ? 0 : c + 1;
      qq = qq ^ w;
      step(0, 0, 1, 1, '0, c, w, qq);
    end
  endtask

  // monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks += 4;
        if (count !== x.cnt) begin
          errors++;
          $display("FAIL step%0d count got %0d exp %0d", x.id, count, x.cnt);
        end
        if (tc !== x.tc) begin
          errors++;
          $display("FAIL step%0d tc got %b exp %b", x.id, tc, x.tc);
        end
        if (q !== x.q) begin
          errors++;
          $display("FAIL step%0d q got %b exp %b", x.id, q, x.q);
        end
        if (qbar !== ~x.q) begin
          errors++;
          $display("FAIL step%0d qbar got %b exp %b", x.id, qbar, ~x.q);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; mod_in = '0;

    // 1: reset with random other inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), 0, 0, 0);

    // 2: count up through the default modulus 10: 1..9,0,1,2
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 1, '0, i, 0, 0);
    step(0, 0, 1, 1, '0, 0, 1, 1);
    step(0, 0, 1, 1, '0, 1, 0, 1);
    step(0, 0, 1, 1, '0, 2, 0, 1);

    // 3: load 5 (en ignored), count down: 4,3,2,1,0,4
    step(0, 1, 1, 1, 4'd5, 0, 0, 1);
    step(0, 0, 1, 0, '0, 4, 1, 0);
    step(0, 0, 1, 0, '0, 3, 0, 0);
    step(0, 0, 1, 0, '0, 2, 0, 0);
    step(0, 0, 1, 0, '0, 1, 0, 0);
    step(0, 0, 1, 0, '0, 0, 0, 0);
    step(0, 0, 1, 0, '0, 4, 1, 1);

    // 4: reach 3, hold 4 cycles, resume upward to 4 then wrap
    step(0, 0, 1, 0, '0, 3, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1'($urandom), '0, 3, 0, 1);
    step(0, 0, 1, 1, '0, 4, 0, 1);
    step(0, 0, 1, 1, '0, 0, 1, 0);

    // 5: mod 10, count to 6, load mod 0 with en high, then 16 cycles to tc
    step(0, 1, 0, 1, 4'd10, 0, 0, 0);
    run_up(6, 0, 10, 0);
    step(0, 1, 1, 1, 4'd0, 0, 0, 0);
    run_up(16, 0, 16, 0);
    // count 0, q 1; up to 6 then rst+load+en together
    run_up(6, 0, 16, 1);
    step(1, 1, 1, 1, 4'd3, 0, 0, 0);
    // modulus back to default 10
    run_up(10, 0, 10, 0);

    // 6: M=1 from a fresh reset; every enabled edge wraps
    step(1, 0, 0, 0, '0, 0, 0, 0);
    step(0, 1, 0, 1, 4'd1, 0, 0, 0);
    step(0, 0, 1, 1, '0, 0, 1, 1);
    step(0, 0, 1, 1, '0, 0, 1, 0);
    step(0, 0, 1, 1, '0, 0, 1, 1);
    step(0, 0, 1, 1, '0, 0, 1, 0);
    step(0, 0, 1, 0, '0, 0, 1, 1);
    step(0, 0, 0, 0, '0, 0, 0, 1);
    // load while tc high clears tc, keeps q
    step(0, 0, 1, 1, '0, 0, 1, 0);
    step(0, 1, 1, 1, 4'd3, 0, 0, 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain queue left %0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
